// File: rtl/batrider_gp9001_pkg.sv
// Shared types and the CPU-offset decode for the Batrider GP9001 bus initiator.
package batrider_gp9001_pkg;

  // Word offsets inside the GP9001 register window.
  localparam logic [2:0] OFF_PTR   = 3'd0;
  localparam logic [2:0] OFF_RAM   = 3'd2;
  localparam logic [2:0] OFF_RAM_L = 3'd3;
  localparam logic [2:0] OFF_SEL   = 3'd4;
  localparam logic [2:0] OFF_REG   = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  // One-hot GP9001 operation; all-zero means the access is unmapped.
  typedef struct packed {
    logic objectbank_wr;
    logic set_ram_ptr;
    logic read_ram_l;
    logic read_ram_h;
    logic write_ram;
    logic write_reg;
    logic select_reg;
  } op_t;

  localparam op_t OpNone = '0;

  // CPU_CS takes priority over the object bank select.
  function automatic op_t decode_op(input logic       cs,
                                    input logic       objbank_cs,
                                    input logic [2:0] addr,
                                    input logic       rnw);
    op_t op;
    op = OpNone;
    if (cs) begin
      case (addr)
        OFF_PTR:   op.set_ram_ptr = ~rnw;
        OFF_RAM: begin
          op.read_ram_h = rnw;
          op.write_ram  = ~rnw;
        end
        OFF_RAM_L: op.read_ram_l  = rnw;
        OFF_SEL:   op.select_reg  = ~rnw;
        OFF_REG:   op.write_reg   = ~rnw;
        default:   op = OpNone;
      endcase
    end else if (objbank_cs) begin
      op.objectbank_wr = ~rnw;
    end
    return op;
  endfunction

endpackage

// File: rtl/batrider_gp9001_bus.sv
// CPU-side initiator: turns decoded 68000 accesses into GP9001 op strobes with a
// chip-select/acknowledge handshake and returns DTACK plus read data.
module batrider_gp9001_bus
  import batrider_gp9001_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_CS,
  input  logic        CPU_OBJBANK_CS,
  input  logic [2:0]  CPU_ADDR,
  input  logic        CPU_RNW,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        CPU_DTACK,
  output logic        BUS_ERR,
  output logic        GP9001CS,
  input  logic        GP9001ACK,
  output logic [15:0] GP9001DIN,
  input  logic [15:0] GP9001DOUT,
  output logic        GP9001_OP_SELECT_REG,
  output logic        GP9001_OP_WRITE_REG,
  output logic        GP9001_OP_WRITE_RAM,
  output logic        GP9001_OP_READ_RAM_H,
  output logic        GP9001_OP_READ_RAM_L,
  output logic        GP9001_OP_SET_RAM_PTR,
  output logic        GP9001_OP_OBJECTBANK_WR,
  output logic [2:0]  GP9001_OBJECTBANK_SLOT
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  op_t         op_q, op_d, op_dec;
  logic        gp_cs_q, gp_cs_d;
  logic        dtack_q, dtack_d;
  logic        bus_err_q, bus_err_d;
  logic        rnw_q, rnw_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] din_q, din_d;
  logic [2:0]  slot_q, slot_d;

  // Next-state and registered-output logic for the IDLE/REQ/DONE handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    gp_cs_d   = gp_cs_q;
    dtack_d   = dtack_q;
    bus_err_d = 1'b0;
    rnw_d     = rnw_q;
    dout_d    = dout_q;
    din_d     = din_q;
    slot_d    = slot_q;
    op_dec    = decode_op(CPU_CS, CPU_OBJBANK_CS, CPU_ADDR, CPU_RNW);
    // Saturating so a large count can never wrap back under the limit.
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (CPU_CS || CPU_OBJBANK_CS) begin
          if (op_dec != OpNone) begin
            state_d = StReq;
            op_d    = op_dec;
            gp_cs_d = 1'b1;
            rnw_d   = CPU_RNW;
            din_d   = CPU_DIN;
            slot_d  = CPU_ADDR;
            cnt_d   = 8'd0;
          end else begin
            state_d = StDone;
            dtack_d = 1'b1;
            dout_d  = 16'hFFFF;
          end
        end
      end
      StReq: begin
        if (GP9001ACK || (cnt_inc == TimeoutCnt)) begin
          state_d = StDone;
          op_d    = OpNone;
          gp_cs_d = 1'b0;
          dtack_d = 1'b1;
          if (GP9001ACK) begin
            if (rnw_q) dout_d = GP9001DOUT;
          end else begin
            bus_err_d = 1'b1;
            dout_d    = 16'hFFFF;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        if (!CPU_CS && !CPU_OBJBANK_CS) begin
          state_d = StIdle;
          dtack_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        op_d    = OpNone;
        gp_cs_d = 1'b0;
        dtack_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      op_q      <= OpNone;
      gp_cs_q   <= 1'b0;
      dtack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      rnw_q     <= 1'b0;
      dout_q    <= 16'd0;
      din_q     <= 16'd0;
      slot_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      gp_cs_q   <= gp_cs_d;
      dtack_q   <= dtack_d;
      bus_err_q <= bus_err_d;
      rnw_q     <= rnw_d;
      dout_q    <= dout_d;
      din_q     <= din_d;
      slot_q    <= slot_d;
    end
  end

  assign CPU_DOUT                = dout_q;
  assign CPU_DTACK               = dtack_q;
  assign BUS_ERR                 = bus_err_q;
  assign GP9001CS                = gp_cs_q;
  assign GP9001DIN               = din_q;
  assign GP9001_OBJECTBANK_SLOT  = slot_q;
  assign GP9001_OP_SELECT_REG    = op_q.select_reg;
  assign GP9001_OP_WRITE_REG     = op_q.write_reg;
  assign GP9001_OP_WRITE_RAM     = op_q.write_ram;
  assign GP9001_OP_READ_RAM_H    = op_q.read_ram_h;
  assign GP9001_OP_READ_RAM_L    = op_q.read_ram_l;
  assign GP9001_OP_SET_RAM_PTR   = op_q.set_ram_ptr;
  assign GP9001_OP_OBJECTBANK_WR = op_q.objectbank_wr;

endmodule

// File: doc/batrider_gp9001_bus.md
# batrider_gp9001_bus

CPU-side bus initiator for the GP9001 graphics controller port of the Batrider video subsystem. It converts 68000 accesses in the GP9001 address window into one-hot GP9001 operation strobes with a chip-select/acknowledge handshake. It returns read data and a DTACK-style completion to the CPU. It sits between the main CPU address decoder and the `GP9001CS`/`GP9001ACK`/`GP9001_OP_*` inputs of the video block.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles to wait for `GP9001ACK` before forcing completion. Range 1..255; the counter is 8 bits.

Ports:
- `CLK` in 1: the single system clock. All logic is in this domain.
- `RESET` in 1: synchronous, active-high reset.
- `CPU_CS` in 1: CPU access to the GP9001 register window (decoded upstream). It is held for the whole bus cycle.
- `CPU_OBJBANK_CS` in 1: CPU access to the object bank register window.
- `CPU_ADDR` in 3: word offset within the window. For object bank accesses, this is the slot number.
- `CPU_RNW` in 1: 1 = read, 0 = write.
- `CPU_DIN` in 16: CPU write data.
- `CPU_DOUT` out 16: read data returned to the CPU.
- `CPU_DTACK` out 1: access complete. It is held until both chip selects drop.
- `BUS_ERR` out 1: one-cycle pulse when an access times out.
- `GP9001CS` out 1: request to the GP9001.
- `GP9001ACK` in 1: GP9001 acknowledge.
- `GP9001DIN` out 16: data to the GP9001.
- `GP9001DOUT` in 16: data from the GP9001.
- `GP9001_OP_SELECT_REG` out 1: operation strobe.
- `GP9001_OP_WRITE_REG` out 1: operation strobe.
- `GP9001_OP_WRITE_RAM` out 1: operation strobe.
- `GP9001_OP_READ_RAM_H` out 1: operation strobe.
- `GP9001_OP_READ_RAM_L` out 1: operation strobe.
- `GP9001_OP_SET_RAM_PTR` out 1: operation strobe.
- `GP9001_OP_OBJECTBANK_WR` out 1: operation strobe.
- `GP9001_OBJECTBANK_SLOT` out 3: object bank slot number.

## Operation
Offset decode for `CPU_CS` (write / read):
- 0: `SET_RAM_PTR` / unmapped.
- 2: `WRITE_RAM` / `READ_RAM_H`.
- 3: unmapped / `READ_RAM_L`.
- 4: `SELECT_REG` / unmapped.
- 6: `WRITE_REG` / unmapped.
- 1, 5, 7: unmapped in both directions.

Object bank decode (`CPU_OBJBANK_CS`):
- A write issues `OBJECTBANK_WR` with `GP9001_OBJECTBANK_SLOT` = `CPU_ADDR`.
- A read is unmapped.

Unmapped accesses complete without touching the GP9001. `CPU_DOUT` = 0xFFFF.

If both chip selects are high together, `CPU_CS` wins.

State machine:
- `IDLE`
  - Any chip select high and the access is mapped: latch the op, `CPU_DIN` into `GP9001DIN`, and the slot. Go to `REQ`.
  - Any chip select high and the access is unmapped: go to `DONE` with `CPU_DOUT` = 0xFFFF.
- `REQ`
  - `GP9001CS` and exactly one op strobe are high. Both are held steady.
  - `GP9001ACK` = 1: latch `GP9001DOUT` into `CPU_DOUT` on reads. Go to `DONE`.
  - The timeout counter reaches `TIMEOUT` first: pulse `BUS_ERR`, set `CPU_DOUT` = 0xFFFF, go to `DONE`.
- `DONE`
  - `CPU_DTACK` = 1. `GP9001CS` and all strobes are 0.
  - Both chip selects low: go to `IDLE`.

Edge rule: a new access starts only from `IDLE`, so the CPU must drop its chip select between accesses.

The timeout counter clears on entry to `REQ` and saturates. It does not wrap.

The contents of `CPU_DOUT` after a write are don't-care; the implementation leaves it unchanged.

## Timing
- Reset value of every output is 0, and the state is `IDLE`.
- Reset mid-access: strobes and `CPU_DTACK` drop on the next edge. The access is abandoned and no ACK is awaited.
- Mapped access:
  - `CPU_CS` is sampled at edge N.
  - `GP9001CS` and the op strobe are high from N+1.
  - `GP9001ACK` is sampled at edge M. At M+1, `GP9001CS` is 0, `CPU_DTACK` is 1 and `CPU_DOUT` is valid.
  - Minimum latency from chip select to DTACK is 2 cycles, when ACK arrives in the first `REQ` cycle.
- Unmapped access: `CPU_DTACK` at N+1.
- Timeout: `BUS_ERR` and `CPU_DTACK` rise together at edge N+1+`TIMEOUT`.
- Chip select drop is seen at edge K. At K+1, `CPU_DTACK` is 0 and the state is `IDLE`. The next access can be sampled at K+1.
- `GP9001ACK` outside `REQ` is ignored.

## Structure
- Package `batrider_gp9001_pkg` holds:
  - the offset localparams `OFF_PTR`=0, `OFF_RAM`=2, `OFF_RAM_L`=3, `OFF_SEL`=4, `OFF_REG`=6;
  - the state enum `IDLE`/`REQ`/`DONE`;
  - an op one-hot type.
- A single flat module. No sub-module is needed; the decode is a function in the package.

## Test plan
- Write 0x1234 to offset 4, ACK after 3 cycles:
  - `SELECT_REG` is the only strobe, held 3 cycles, with `GP9001DIN`=0x1234.
  - DTACK rises the cycle after ACK.
- Read offset 2 with `GP9001DOUT`=0xBEEF and ACK immediate:
  - `READ_RAM_H` is strobed.
  - `CPU_DOUT`=0xBEEF with DTACK 2 cycles after CS.
- Read offset 3 then offset 5, back to back with a one-cycle CS gap:
  - the first access issues `READ_RAM_L`;
  - the second returns 0xFFFF with DTACK after 1 cycle and no `GP9001CS`.
- Object bank write, slot 5, data 0x0007:
  - `OBJECTBANK_WR` and slot=5 are high until ACK.
  - `CPU_CS` and `CPU_OBJBANK_CS` asserted together: the `CPU_CS` op is issued.
- Read at offset 2, `TIMEOUT`=8, ACK never arrives:
  - `BUS_ERR` pulses once 9 cycles after CS, together with DTACK and `CPU_DOUT`=0xFFFF.
  - A late ACK is ignored.
- Assert `RESET` during `REQ`: all outputs are 0 the next cycle, then a fresh access completes normally.
